// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the AXI interconnect write-address path.
//   aw_dec_state_t     : write-address decoder FSM states
//   Burst*             : AXI awburst encodings
//   DefaultSlaveFromTop: unmapped addresses fall back to slave (Slaves_Num - this)
//   outstanding_width(): width of a 0..max_outstanding counter
package axi_ic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StIssue,
        StWaitDrain
    } aw_dec_state_t;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    localparam int unsigned DefaultSlaveFromTop = 1;

    function automatic int unsigned outstanding_width(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/aw_outstanding_ctr.sv
// Saturating up/down counter of issued writes awaiting their B response.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : a write was issued this cycle
//   dec_i         : a write response completed this cycle (ignored at zero)
//   count_o       : current count, never wraps in either direction
//   full_o        : count_o == MaxCount
module aw_outstanding_ctr
    import axi_ic_pkg::*;
#(
    parameter int unsigned MaxCount = 4,
    parameter int unsigned CountW   = outstanding_width(MaxCount)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [CountW-1:0] count_o,
    output logic              full_o
);

    localparam logic [CountW-1:0] MaxVal = CountW'(MaxCount);

    logic [CountW-1:0] count_q, count_d;
    logic              full, empty;
    logic              dec_ok, inc_ok;

    assign full  = (count_q == MaxVal);
    assign empty = (count_q == '0);

    // A decrement at zero is dropped; an increment at full is only legal when a
    // decrement frees a slot in the same cycle.
    assign dec_ok = dec_i && !empty;
    assign inc_ok = inc_i && (!full || dec_ok);

    always_comb begin
        count_d = count_q;
        if (inc_ok && !dec_ok) begin
            count_d = count_q + CountW'(1);
        end else if (dec_ok && !inc_ok) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = full;

endmodule

// File: rtl/axi_aw_decoder_n.sv
// Registered AXI write-address decoder for Slaves_Num slaves.
// The top Base_Addr_Width address bits select the slave. One AW beat is held at a
// time; the target slave may only change once every earlier write has its B response.
//   ACLK, ARESETN         : clock, asynchronous active-low reset
//   S_aw*                 : master-side AW channel (from the AW arbiter)
//   M_aw* fields          : registered AW beat, shared by all slaves
//   M_awaddr_ID           : registered slave index
//   M_awvalid/M_awready   : per-slave handshake, at most one valid bit set
//   B_done                : one-cycle pulse per completed write response
//   Q_Enables             : one-hot pulse on each issue handshake (write-data routing)
//   Sel_Slave_Ready       : ready of the selected slave while issuing
//   Outstanding           : writes issued and not yet completed
//   Dec_Err               : one-cycle pulse after an unmapped address is accepted
// Build option AW_DECERR_EN: when defined, unmapped addresses are absorbed and flagged
// on Dec_Err; otherwise they route to slave Slaves_Num-1 and Dec_Err stays 0.
module axi_aw_decoder_n
    import axi_ic_pkg::*;
#(
    parameter int unsigned Address_width   = 32,
    parameter int unsigned Base_Addr_Width = 2,
    parameter int unsigned Slaves_Num      = 4,
    parameter int unsigned Slaves_ID_Size  = $clog2(Slaves_Num),
    parameter int unsigned Aw_len          = 8,
    parameter int unsigned Max_Outstanding = 4,
    localparam int unsigned OutW           = outstanding_width(Max_Outstanding)
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [Address_width-1:0]  S_awaddr,
    input  logic [Aw_len-1:0]         S_awlen,
    input  logic [2:0]                S_awsize,
    input  logic [1:0]                S_awburst,
    input  logic [1:0]                S_awlock,
    input  logic [3:0]                S_awcache,
    input  logic [2:0]                S_awprot,
    input  logic [3:0]                S_awqos,
    input  logic                      S_awvalid,
    output logic                      S_awready,
    output logic [Address_width-1:0]  M_awaddr,
    output logic [Aw_len-1:0]         M_awlen,
    output logic [2:0]                M_awsize,
    output logic [1:0]                M_awburst,
    output logic [1:0]                M_awlock,
    output logic [3:0]                M_awcache,
    output logic [2:0]                M_awprot,
    output logic [3:0]                M_awqos,
    output logic [Slaves_ID_Size-1:0] M_awaddr_ID,
    output logic [Slaves_Num-1:0]     M_awvalid,
    input  logic [Slaves_Num-1:0]     M_awready,
    input  logic                      B_done,
    output logic [Slaves_Num-1:0]     Q_Enables,
    output logic                      Sel_Slave_Ready,
    output logic [OutW-1:0]           Outstanding,
    output logic                      Dec_Err
);

    localparam int unsigned IdxExtW = Base_Addr_Width + 1;
    localparam logic [IdxExtW-1:0] SlavesNumExt = IdxExtW'(Slaves_Num);

    aw_dec_state_t state_q, state_d;

    logic [Base_Addr_Width-1:0] base_idx;
    logic                       unmapped;
    logic [Slaves_ID_Size-1:0]  dec_idx, idx_q, cur_slave_q;
    logic                       s_awready_q;
    logic                       accept, load, issue_hs;
    logic                       dec_err_d, dec_err_q;
    logic [OutW-1:0]            count, count_eff;
    logic                       full, b_dec_eff, same_slave, drained, room, can_issue;

    assign base_idx = S_awaddr[Address_width-1 -: Base_Addr_Width];
    assign unmapped = ({1'b0, base_idx} >= SlavesNumExt);

`ifdef AW_DECERR_EN
    // Unmapped beats never reach the index register, so no fallback is needed.
    assign dec_idx = base_idx[Slaves_ID_Size-1:0];
`else
    localparam logic [Slaves_ID_Size-1:0] DefSlave =
        Slaves_ID_Size'(Slaves_Num - DefaultSlaveFromTop);
    assign dec_idx = unmapped ? DefSlave : base_idx[Slaves_ID_Size-1:0];
`endif

    assign accept   = S_awvalid && s_awready_q;
    assign issue_hs = (state_q == StIssue) && M_awready[idx_q];
    assign load     = (state_q == StIdle) && (state_d == StCheck);

    // Issue decision sees a B_done arriving in the same cycle, so a drain releases
    // the stalled beat one cycle after the final response.
    assign b_dec_eff  = B_done && (count != '0);
    assign count_eff  = count - OutW'(b_dec_eff);
    assign same_slave = (idx_q == cur_slave_q);
    assign drained    = (count_eff == '0);
    assign room       = !full || B_done;
    assign can_issue  = (same_slave || drained) && room;

    always_comb begin
        state_d   = state_q;
        dec_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef AW_DECERR_EN
                    if (unmapped) begin
                        dec_err_d = 1'b1;
                    end else begin
                        state_d = StCheck;
                    end
`else
                    state_d = StCheck;
`endif
                end
            end
            StCheck, StWaitDrain: begin
                state_d = can_issue ? StIssue : StWaitDrain;
            end
            StIssue: begin
                if (issue_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= StIdle;
            s_awready_q <= 1'b0;
            dec_err_q   <= 1'b0;
            idx_q       <= '0;
            cur_slave_q <= '0;
            M_awaddr    <= '0;
            M_awlen     <= '0;
            M_awsize    <= '0;
            M_awburst   <= '0;
            M_awlock    <= '0;
            M_awcache   <= '0;
            M_awprot    <= '0;
            M_awqos     <= '0;
        end else begin
            state_q     <= state_d;
            s_awready_q <= (state_d == StIdle);
            dec_err_q   <= dec_err_d;
            if (load) begin
                idx_q     <= dec_idx;
                M_awaddr  <= S_awaddr;
                M_awlen   <= S_awlen;
                M_awsize  <= S_awsize;
                M_awburst <= S_awburst;
                M_awlock  <= S_awlock;
                M_awcache <= S_awcache;
                M_awprot  <= S_awprot;
                M_awqos   <= S_awqos;
            end
            if (issue_hs) begin
                cur_slave_q <= idx_q;
            end
        end
    end

    // Valid is decoded from the state register so an asynchronous reset drops it at once.
    always_comb begin
        M_awvalid = '0;
        Q_Enables = '0;
        if (state_q == StIssue) begin
            M_awvalid[idx_q] = 1'b1;
            if (M_awready[idx_q]) begin
                Q_Enables[idx_q] = 1'b1;
            end
        end
    end

    aw_outstanding_ctr #(
        .MaxCount (Max_Outstanding),
        .CountW   (OutW)
    ) u_outstanding_ctr (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .inc_i   (issue_hs),
        .dec_i   (B_done),
        .count_o (count),
        .full_o  (full)
    );

    assign S_awready       = s_awready_q;
    assign M_awaddr_ID     = idx_q;
    assign Sel_Slave_Ready = (state_q == StIssue) && M_awready[idx_q];
    assign Outstanding     = count;
    assign Dec_Err         = dec_err_q;

endmodule

// File: tb/tb_axi_aw_decoder_n.sv
module tb_axi_aw_decoder_n;

    localparam int MaxOut = 4;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b1;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // Shared master-side fields
    logic [31:0] s_awaddr = '0;
    logic [7:0]  s_awlen = '0;
    logic [2:0]  s_awsize = '0;
    logic [1:0]  s_awburst = '0;
    logic [1:0]  s_awlock = '0;
    logic [3:0]  s_awcache = '0;
    logic [2:0]  s_awprot = '0;
    logic [3:0]  s_awqos = '0;

    // Four-slave instance
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst, m_awlock;
    logic [3:0]  m_awcache, m_awqos;
    logic [2:0]  m_awprot;
    logic [1:0]  m_awaddr_id;
    logic [3:0]  m_awvalid;
    logic [3:0]  m_awready = '0;
    logic        b_done = 1'b0;
    logic [3:0]  q_en;
    logic        sel_rdy;
    logic [2:0]  outst;
    logic        dec_err;

    // Three-slave instance
    logic        s_awvalid3 = 1'b0;
    logic        s_awready3;
    logic [31:0] m3_awaddr;
    logic [7:0]  m3_awlen;
    logic [2:0]  m3_awsize;
    logic [1:0]  m3_awburst, m3_awlock;
    logic [3:0]  m3_awcache, m3_awqos;
    logic [2:0]  m3_awprot;
    logic [1:0]  m3_awaddr_id;
    logic [2:0]  m_awvalid3;
    logic [2:0]  m_awready3 = 3'b111;
    logic        b_done3 = 1'b0;
    logic [2:0]  q_en3;
    logic        sel_rdy3;
    logic [2:0]  outst3;
    logic        dec_err3;

    axi_aw_decoder_n #(.Slaves_Num(4), .Max_Outstanding(MaxOut)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_awaddr(s_awaddr), .S_awlen(s_awlen), .S_awsize(s_awsize), .S_awburst(s_awburst),
        .S_awlock(s_awlock), .S_awcache(s_awcache), .S_awprot(s_awprot), .S_awqos(s_awqos),
        .S_awvalid(s_awvalid), .S_awready(s_awready),
        .M_awaddr(m_awaddr), .M_awlen(m_awlen), .M_awsize(m_awsize), .M_awburst(m_awburst),
        .M_awlock(m_awlock), .M_awcache(m_awcache), .M_awprot(m_awprot), .M_awqos(m_awqos),
        .M_awaddr_ID(m_awaddr_id), .M_awvalid(m_awvalid), .M_awready(m_awready),
        .B_done(b_done), .Q_Enables(q_en), .Sel_Slave_Ready(sel_rdy),
        .Outstanding(outst), .Dec_Err(dec_err)
    );

    axi_aw_decoder_n #(.Slaves_Num(3), .Max_Outstanding(MaxOut)) dut3 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_awaddr(s_awaddr), .S_awlen(s_awlen), .S_awsize(s_awsize), .S_awburst(s_awburst),
        .S_awlock(s_awlock), .S_awcache(s_awcache), .S_awprot(s_awprot), .S_awqos(s_awqos),
        .S_awvalid(s_awvalid3), .S_awready(s_awready3),
        .M_awaddr(m3_awaddr), .M_awlen(m3_awlen), .M_awsize(m3_awsize), .M_awburst(m3_awburst),
        .M_awlock(m3_awlock), .M_awcache(m3_awcache), .M_awprot(m3_awprot), .M_awqos(m3_awqos),
        .M_awaddr_ID(m3_awaddr_id), .M_awvalid(m_awvalid3), .M_awready(m_awready3),
        .B_done(b_done3), .Q_Enables(q_en3), .Sel_Slave_Ready(sel_rdy3),
        .Outstanding(outst3), .Dec_Err(dec_err3)
    );

    // Transaction-level reference: writes in flight and the slave they target.
    int m_cnt = 0;
    int m_cur = 0;

    function automatic bit may_issue(input int tgt);
        return ((tgt == m_cur) || (m_cnt == 0)) && (m_cnt < MaxOut);
    endfunction

    // All tasks start and end 1 time unit after a falling clock edge.
    task automatic pulse_b();
        b_done = 1'b1;
        @(negedge ACLK);
        b_done = 1'b0;
        if (m_cnt > 0) m_cnt--;
        #1;
        n_checks++;
        if (outst !== 3'(m_cnt)) begin
            n_fail++; $display("FAIL idle_bdone: Outstanding=%0d expected %0d", outst, m_cnt);
        end
    endtask

    task automatic drain();
        int n;
        n = m_cnt + 1;
        for (int i = 0; i < n; i++) pulse_b();
    endtask

    task automatic do_write(input logic [31:0] addr, input int rdy_delay, input int stall_wait,
                            input bit bd_at_hs, output int hs_cyc);
        int tgt, guard;
        bit ok;
        logic [3:0]  oh;
        logic [57:0] exp_f;
        tgt = int'(addr[31:30]);
        oh = 4'b0001 << tgt;
        hs_cyc = 0;
        s_awaddr = addr; s_awlen = 8'($urandom); s_awsize = 3'($urandom);
        s_awburst = 2'($urandom); s_awlock = 2'($urandom); s_awcache = 4'($urandom);
        s_awprot = 3'($urandom); s_awqos = 4'($urandom);
        exp_f = {s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos};
        s_awvalid = 1'b1;
        #1;
        guard = 0;
        while (!s_awready && guard < 8) begin @(negedge ACLK); #1; guard++; end
        n_checks++;
        if (s_awready !== 1'b1) begin
            n_fail++; $display("FAIL accept_wait: S_awready=%b expected 1", s_awready);
        end
        @(negedge ACLK);
        s_awvalid = 1'b0;
        s_awaddr = $urandom;
        #1;
        n_checks++;
        if ({s_awready, m_awvalid, dec_err} !== 6'b0) begin
            n_fail++; $display("FAIL check_phase: ready=%b valid=%b dec_err=%b expected all 0",
                               s_awready, m_awvalid, dec_err);
        end
        ok = may_issue(tgt);
        @(negedge ACLK); #1;
        n_checks++;
        if (m_awvalid !== (ok ? oh : 4'b0)) begin
            n_fail++; $display("FAIL issue_or_stall: M_awvalid=%b expected %b", m_awvalid,
                               ok ? oh : 4'b0);
        end
        for (int i = 0; i < stall_wait && !ok; i++) begin
            @(negedge ACLK); #1;
            n_checks++;
            if (m_awvalid !== 4'b0) begin
                n_fail++; $display("FAIL held_stall: M_awvalid=%b expected 0000", m_awvalid);
            end
        end
        guard = 0;
        while (!ok && guard <= MaxOut) begin
            b_done = 1'b1;
            @(negedge ACLK);
            b_done = 1'b0;
            if (m_cnt > 0) m_cnt--;
            ok = may_issue(tgt);
            guard++;
            #1;
            n_checks++;
            if (m_awvalid !== (ok ? oh : 4'b0)) begin
                n_fail++; $display("FAIL drain_release: M_awvalid=%b expected %b", m_awvalid,
                                   ok ? oh : 4'b0);
            end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: model never released slave %0d", tgt);
            return;
        end
        for (int i = 0; i < rdy_delay; i++) begin
            m_awready = 4'($urandom) & ~oh;
            #1;
            n_checks++;
            if ({m_awvalid, q_en, sel_rdy} !== {oh, 4'b0, 1'b0}) begin
                n_fail++; $display("FAIL wait_ready: valid=%b q_en=%b sel=%b expected %b 0000 0",
                                   m_awvalid, q_en, sel_rdy, oh);
            end
            @(negedge ACLK); #1;
        end
        m_awready = 4'($urandom) | oh;
        b_done = bd_at_hs;
        #1;
        hs_cyc = cyc;
        n_checks++;
        if ({m_awvalid, q_en, sel_rdy} !== {oh, oh, 1'b1}) begin
            n_fail++; $display("FAIL handshake: valid=%b q_en=%b sel=%b expected %b %b 1",
                               m_awvalid, q_en, sel_rdy, oh, oh);
        end
        n_checks++;
        if ({m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos,
             m_awaddr_id} !== {exp_f, 2'(tgt)}) begin
            n_fail++; $display("FAIL held_fields: addr=%h id=%0d expected addr=%h id=%0d",
                               m_awaddr, m_awaddr_id, addr, tgt);
        end
        if (!(bd_at_hs && m_cnt > 0)) m_cnt++;
        m_cur = tgt;
        @(negedge ACLK);
        m_awready = '0;
        b_done = 1'b0;
        #1;
        n_checks++;
        if ({outst, q_en, m_awvalid, s_awready} !== {3'(m_cnt), 4'b0, 4'b0, 1'b1}) begin
            n_fail++; $display("FAIL post_issue: cnt=%0d q_en=%b valid=%b ready=%b expected %0d 0000 0000 1",
                               outst, q_en, m_awvalid, s_awready, m_cnt);
        end
    endtask

    task automatic test_reset();
        #2 ARESETN = 1'b0;
        #1;
        n_checks++;
        if ({s_awready, m_awvalid, q_en, dec_err, outst, s_awready3, m_awvalid3} !== 16'b0) begin
            n_fail++; $display("FAIL reset_ctrl: ready=%b valid=%b q_en=%b dec_err=%b cnt=%0d expected 0",
                               s_awready, m_awvalid, q_en, dec_err, outst);
        end
        n_checks++;
        if ({m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos,
             m_awaddr_id} !== 60'b0) begin
            n_fail++; $display("FAIL reset_fields: addr=%h len=%h id=%0d expected 0",
                               m_awaddr, m_awlen, m_awaddr_id);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK); #1;
        n_checks++;
        if (s_awready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: S_awready=%b expected 1", s_awready);
        end
        m_cnt = 0; m_cur = 0;
    endtask

    task automatic test_first_write();
        int h;
        drain();
        do_write(32'h8000_0100, 0, 0, 1'b0, h);
        n_checks++;
        if (outst !== 3'd1) begin
            n_fail++; $display("FAIL first_write_count: Outstanding=%0d expected 1", outst);
        end
    endtask

    task automatic test_back_to_back();
        int h1, h2;
        drain();
        do_write(32'h4000_0000, 0, 0, 1'b0, h1);
        do_write(32'h4000_0000, 0, 0, 1'b0, h2);
        n_checks++;
        if (h2 - h1 !== 3) begin
            n_fail++; $display("FAIL b2b_spacing: %0d cycles expected 3", h2 - h1);
        end
        n_checks++;
        if (outst !== 3'd2) begin
            n_fail++; $display("FAIL b2b_count: Outstanding=%0d expected 2", outst);
        end
    endtask

    task automatic test_drain_switch();
        int h;
        drain();
        do_write(32'h4000_0000, 0, 0, 1'b0, h);
        do_write(32'hC000_0000, 1, 2, 1'b0, h);
        n_checks++;
        if (outst !== 3'd1) begin
            n_fail++; $display("FAIL switch_count: Outstanding=%0d expected 1", outst);
        end
    endtask

    task automatic test_max_outstanding();
        int h;
        drain();
        for (int i = 0; i < MaxOut; i++) do_write(32'h0000_0000 + 32'(i * 16), 0, 0, 1'b0, h);
        n_checks++;
        if (outst !== 3'd4) begin
            n_fail++; $display("FAIL max_count: Outstanding=%0d expected 4", outst);
        end
        do_write(32'h0000_0040, 0, 3, 1'b0, h);
        n_checks++;
        if (outst !== 3'd4) begin
            n_fail++; $display("FAIL max_refill: Outstanding=%0d expected 4", outst);
        end
        // B_done coinciding with the handshake keeps the count level
        do_write(32'h0000_0080, 0, 0, 1'b1, h);
        n_checks++;
        if (outst !== 3'd3) begin
            n_fail++; $display("FAIL inc_dec_same_cycle: Outstanding=%0d expected 3", outst);
        end
    endtask

    task automatic test_unmapped();
        s_awaddr = 32'hC000_0000;
        s_awvalid3 = 1'b1;
        m_awready3 = 3'b111;
        #1;
        n_checks++;
        if (s_awready3 !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_ready: S_awready=%b expected 1", s_awready3);
        end
        @(negedge ACLK);
        s_awvalid3 = 1'b0;
        #1;
`ifdef AW_DECERR_EN
        n_checks++;
        if ({dec_err3, m_awvalid3, s_awready3} !== 5'b1_000_1) begin
            n_fail++; $display("FAIL decerr_pulse: dec_err=%b valid=%b ready=%b expected 1 000 1",
                               dec_err3, m_awvalid3, s_awready3);
        end
        @(negedge ACLK); #1;
        n_checks++;
        if ({dec_err3, m_awvalid3} !== 4'b0) begin
            n_fail++; $display("FAIL decerr_once: dec_err=%b valid=%b expected 0 000",
                               dec_err3, m_awvalid3);
        end
        @(negedge ACLK); #1;
        n_checks++;
        if ({m_awvalid3, outst3} !== 6'b0) begin
            n_fail++; $display("FAIL decerr_no_issue: valid=%b cnt=%0d expected 000 0",
                               m_awvalid3, outst3);
        end
`else
        n_checks++;
        if (dec_err3 !== 1'b0) begin
            n_fail++; $display("FAIL dec_err_tied: Dec_Err=%b expected 0", dec_err3);
        end
        @(negedge ACLK); #1;
        n_checks++;
        if ({m_awvalid3, q_en3, m3_awaddr_id} !== {3'b100, 3'b100, 2'd2}) begin
            n_fail++; $display("FAIL default_slave: valid=%b q_en=%b id=%0d expected 100 100 2",
                               m_awvalid3, q_en3, m3_awaddr_id);
        end
        @(negedge ACLK); #1;
        n_checks++;
        if ({m_awvalid3, outst3, dec_err3} !== {3'b000, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL default_count: valid=%b cnt=%0d dec_err=%b expected 000 1 0",
                               m_awvalid3, outst3, dec_err3);
        end
`endif
    endtask

    task automatic test_random();
        int h, sl;
        logic [31:0] a;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) pulse_b();
            sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : m_cur;
            a = {2'(sl), 30'($urandom)};
            do_write(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                     ($urandom_range(0, 3) == 0), h);
        end
    endtask

    task automatic test_reset_mid_issue();
        drain();
        s_awaddr = 32'h8000_0000;
        s_awvalid = 1'b1;
        m_awready = '0;
        @(negedge ACLK);
        s_awvalid = 1'b0;
        @(negedge ACLK); #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (m_awvalid !== 4'b0100) begin
                n_fail++; $display("FAIL stuck_issue: M_awvalid=%b expected 0100", m_awvalid);
            end
            @(negedge ACLK); #1;
        end
        ARESETN = 1'b0;
        #1;
        m_cnt = 0; m_cur = 0;
        n_checks++;
        if ({m_awvalid, q_en, outst, s_awready} !== 12'b0) begin
            n_fail++; $display("FAIL mid_reset: valid=%b q_en=%b cnt=%0d ready=%b expected all 0",
                               m_awvalid, q_en, outst, s_awready);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK); #1;
        n_checks++;
        if ({s_awready, m_awvalid} !== 5'b1_0000) begin
            n_fail++; $display("FAIL after_reset: ready=%b valid=%b expected 1 0000",
                               s_awready, m_awvalid);
        end
    endtask

    initial begin
        test_reset();
        test_unmapped();
        test_first_write();
        test_back_to_back();
        test_drain_switch();
        test_max_outstanding();
        test_random();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
